// File: rtl/stopwatch_bcd_chain.sv
// stopwatch_bcd_chain: cascaded BCD time counter with run/stop/lap control.
// Digit i counts 0..5 when SEX_MASK[i] is set, otherwise 0..9. Digit 0 is the
// least-significant time unit. display shows a frozen lap snapshot while
// lap_active is high, otherwise it shows the live count.
module stopwatch_bcd_chain #(
    parameter int unsigned          DIGITS   = 6,
    parameter logic [DIGITS-1:0]    SEX_MASK = DIGITS'(6'b101000)
) (
    input  logic                  clk,
    input  logic                  r,
    input  logic                  tick,
    input  logic                  start_stop,
    input  logic                  lap,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   display,
    output logic                  running,
    output logic                  lap_active,
    output logic                  overflow,
    output logic                  carry_out
);

    localparam int unsigned CW = 4 * DIGITS;

    typedef enum logic [1:0] {
        CLEARED = 2'd0,
        RUN     = 2'd1,
        STOP    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   snap_q, snap_d;
    logic            lap_q, lap_d;
    logic            ovf_q, ovf_d;
    logic            carry_q, carry_d;
    logic            run_q;

    logic            inc_c;
    logic            clr_c;
    logic            wrap_c;
    logic [CW-1:0]   count_inc_c;
    logic            chain_en;
    logic [3:0]      dig;
    logic [3:0]      dmax;

    assign inc_c = tick && (state_q == RUN);
    assign clr_c = clear || (lap && (state_q == STOP));

    // Ripple carry chain: each digit advances when all lower digits are at max.
    always_comb begin
        chain_en    = inc_c;
        count_inc_c = count_q;
        dig         = 4'd0;
        dmax        = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig  = count_q[4*i +: 4];
            dmax = SEX_MASK[i] ? 4'd5 : 4'd9;
            if (chain_en) begin
                // At max wraps to 0; an illegal code (> max) is also forced to 0.
                count_inc_c[4*i +: 4] = (dig >= dmax) ? 4'd0 : dig + 4'd1;
            end
            chain_en = chain_en && (dig == dmax);
        end
        wrap_c = chain_en;
    end

    // Next-state and datapath decode; clear has priority over everything else.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        ovf_d   = ovf_q;
        carry_d = 1'b0;

        if (clr_c) begin
            state_d = CLEARED;
            count_d = '0;
            snap_d  = '0;
            lap_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            count_d = count_inc_c;
            carry_d = wrap_c;
            if (wrap_c) begin
                ovf_d = 1'b1;
            end
            case (state_q)
                CLEARED: begin
                    if (start_stop) state_d = RUN;
                end
                RUN: begin
                    if (start_stop) begin
                        state_d = STOP;
                    end else if (lap) begin
                        lap_d = !lap_q;
                        // Snapshot the pre-increment value on freeze.
                        if (!lap_q) snap_d = count_q;
                    end
                end
                STOP: begin
                    if (start_stop) state_d = RUN;
                end
                default: state_d = CLEARED;
            endcase
        end
    end

    // State and data registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q <= CLEARED;
            count_q <= '0;
            snap_q  <= '0;
            lap_q   <= 1'b0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            snap_q  <= snap_d;
            lap_q   <= lap_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            run_q   <= (state_d == RUN);
        end
    end

    assign count      = count_q;
    assign display    = lap_q ? snap_q : count_q;
    assign running    = run_q;
    assign lap_active = lap_q;
    assign overflow   = ovf_q;
    assign carry_out  = carry_q;

endmodule

// File: tb/tb_stopwatch_bcd_chain.sv
// Directed bench for stopwatch_bcd_chain: a 6-digit default instance, a 4-digit
// instance for a full-chain wrap in few cycles, and a 2-digit instance.
module tb_stopwatch_bcd_chain;

    logic        clk;
    logic        r;
    logic [2:0]  tick_v, ss_v, lap_v, clr_v;

    logic [23:0] count0, display0;
    logic [15:0] count1, display1;
    logic [7:0]  count2, display2;
    logic [2:0]  running_v, lap_active_v, overflow_v, carry_v;

    int n_chk  = 0;
    int n_fail = 0;

    stopwatch_bcd_chain u0 (
        .clk(clk), .r(r), .tick(tick_v[0]), .start_stop(ss_v[0]), .lap(lap_v[0]),
        .clear(clr_v[0]), .count(count0), .display(display0), .running(running_v[0]),
        .lap_active(lap_active_v[0]), .overflow(overflow_v[0]), .carry_out(carry_v[0])
    );

    stopwatch_bcd_chain #(.DIGITS(4), .SEX_MASK(4'b1000)) u1 (
        .clk(clk), .r(r), .tick(tick_v[1]), .start_stop(ss_v[1]), .lap(lap_v[1]),
        .clear(clr_v[1]), .count(count1), .display(display1), .running(running_v[1]),
        .lap_active(lap_active_v[1]), .overflow(overflow_v[1]), .carry_out(carry_v[1])
    );

    stopwatch_bcd_chain #(.DIGITS(2), .SEX_MASK(2'b10)) u2 (
        .clk(clk), .r(r), .tick(tick_v[2]), .start_stop(ss_v[2]), .lap(lap_v[2]),
        .clear(clr_v[2]), .count(count2), .display(display2), .running(running_v[2]),
        .lap_active(lap_active_v[2]), .overflow(overflow_v[2]), .carry_out(carry_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs on instance k; returns 1 time unit after the edge.
    task automatic cyc(input int k, input logic t, input logic s, input logic l, input logic c);
        tick_v[k] = t;
        ss_v[k]   = s;
        lap_v[k]  = l;
        clr_v[k]  = c;
        @(posedge clk);
        #1;
        tick_v[k] = 1'b0;
        ss_v[k]   = 1'b0;
        lap_v[k]  = 1'b0;
        clr_v[k]  = 1'b0;
    endtask

    task automatic ticks(input int k, input int n);
        for (int j = 0; j < n; j++) cyc(k, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        r      = 1'b1;
        tick_v = '0;
        ss_v   = '0;
        lap_v  = '0;
        clr_v  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count0",   32'(count0), 32'h0);
        chk("rst_display0", 32'(display0), 32'h0);
        chk("rst_flags",    32'({running_v, lap_active_v, overflow_v, carry_v}), 32'h0);
        r = 1'b0;

        // Run 1234 ticks, stop with a coincident tick, then idle ticks in STOP.
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_running", 32'(running_v[0]), 32'h1);
        ticks(0, 1234);
        chk("count_1234", 32'(count0), 32'h001234);
        cyc(0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("stop_tick_counted", 32'(count0), 32'h001235);
        chk("stop_running", 32'(running_v[0]), 32'h0);
        ticks(0, 3);
        chk("stop_holds", 32'(count0), 32'h001235);

        // Lap in STOP clears; lap and tick in CLEARED do nothing.
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stop_lap_clears", 32'(count0), 32'h0);
        cyc(0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("cleared_ignores", 32'({count0, lap_active_v[0], running_v[0]}), 32'h0);

        // Starting start_stop with a tick: that tick is not counted.
        cyc(0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("start_tick_dropped", 32'(count0), 32'h0);
        ticks(0, 5999);
        chk("count_5999", 32'(count0), 32'h005999);
        ticks(0, 1);
        chk("carry_to_minute", 32'(count0), 32'h010000);
        chk("no_overflow", 32'({overflow_v[0], carry_v[0]}), 32'h0);

        // Lap freeze and release.
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(0, 42);
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_active_on", 32'(lap_active_v[0]), 32'h1);
        ticks(0, 10);
        chk("lap_display", 32'(display0), 32'h000042);
        chk("lap_count", 32'(count0), 32'h000052);
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_release", 32'({lap_active_v[0], display0}), 32'h0000052);
        cyc(0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("lap_pre_increment", 32'({lap_active_v[0], display0}), 32'h1000052);
        chk("lap_tick_count", 32'(count0), 32'h000053);

        // start_stop beats lap; lap_active survives STOP -> RUN.
        cyc(0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ss_over_lap", 32'({running_v[0], lap_active_v[0], display0}), 32'h1000052);
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("restart_keeps_lap", 32'({running_v[0], lap_active_v[0]}), 32'h3);

        // Clear beats tick and start_stop.
        cyc(0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("clear_count", 32'(count0), 32'h0);
        chk("clear_flags", 32'({running_v[0], lap_active_v[0], overflow_v[0], display0}), 32'h0);
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("clear_is_cleared", 32'(count0), 32'h0);

        // 4-digit full-chain wrap.
        cyc(1, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1, 5999);
        chk("u1_count_5999", 32'(count1), 32'h5999);
        ticks(1, 1);
        chk("u1_wrap", 32'({count1, overflow_v[1], carry_v[1], running_v[1]}), 32'h00007);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("u1_carry_one_cycle", 32'({overflow_v[1], carry_v[1]}), 32'h2);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("u1_clear_overflow", 32'({count1, overflow_v[1], running_v[1]}), 32'h0);

        // 2-digit wrap at 59.
        cyc(2, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2, 59);
        chk("u2_count_59", 32'(count2), 32'h59);
        ticks(2, 1);
        chk("u2_wrap", 32'({count2, overflow_v[2], carry_v[2]}), 32'h003);
        ticks(2, 3);
        chk("u2_after_wrap", 32'({count2, overflow_v[2], carry_v[2]}), 32'h00E);

        // Asynchronous reset mid-run, checked before the next clock edge.
        #2;
        r = 1'b1;
        #1;
        chk("async_rst_u2", 32'({count2, display2, running_v[2], overflow_v[2], carry_v[2]}), 32'h0);
        chk("async_rst_u1", 32'({count1, display1}), 32'h0);
        @(posedge clk);
        #1;
        r = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
